// File: rtl/input_module_16to304_if.sv
// input_module_16to304_if
// Bundles the chunk-side and symbol-side handshake signals of the
// 16-to-304 deserializer.
//   master : the environment (drives chunks in, accepts symbols out)
//   slave  : the deserializer itself
// Signals:
//   valid_in, sof_in, data_in  chunk stream into the block
//   ready_out                  block can take a chunk this cycle
//   data_out, valid_out        assembled symbol and its valid flag
//   ready_in                   consumer takes data_out this cycle
//   frame_err                  one-cycle framing-violation pulse
//   chunk_count                chunks held in the partial frame
interface input_module_16to304_if #(
  parameter int CHUNK_W    = 16,
  parameter int NUM_CHUNKS = 19,
  parameter int CNT_W      = $clog2(NUM_CHUNKS + 1)
);
  logic                          valid_in;
  logic                          sof_in;
  logic [CHUNK_W-1:0]            data_in;
  logic                          ready_out;
  logic [CHUNK_W*NUM_CHUNKS-1:0] data_out;
  logic                          valid_out;
  logic                          ready_in;
  logic                          frame_err;
  logic [CNT_W-1:0]              chunk_count;

  modport master (
    output valid_in, sof_in, data_in, ready_in,
    input  ready_out, data_out, valid_out, frame_err, chunk_count
  );

  modport slave (
    input  valid_in, sof_in, data_in, ready_in,
    output ready_out, data_out, valid_out, frame_err, chunk_count
  );
endinterface

// File: rtl/input_module_16to304.sv
// input_module_16to304
// Receive-side deserializer: gathers NUM_CHUNKS chunks of CHUNK_W bits into
// one symbol word and hands it downstream through a holding register, so the
// next symbol can assemble while the previous one waits for the consumer.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    input_module_16to304_if.slave (chunk stream in, symbol stream out)
module input_module_16to304 #(
  parameter int CHUNK_W    = 16,
  parameter int NUM_CHUNKS = 19
) (
  input  logic                    clk,
  input  logic                    reset,
  input_module_16to304_if.slave   bus
);

  localparam int CNT_W  = $clog2(NUM_CHUNKS + 1);
  localparam int WORD_W = CHUNK_W * NUM_CHUNKS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHUNKS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_CHUNKS);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               frame_err_reg, frame_err_next;
  logic               valid_out_reg;
  logic [WORD_W-1:0]  data_out_reg;

  logic               ready_out;
  logic               accept;
  logic               out_free;
  logic               wr_en;
  logic [CNT_W-1:0]   wr_idx;
  logic               copy;

  logic [CHUNK_W-1:0] asm_reg [NUM_CHUNKS];
  // Assembly as it will look after this edge: lets the completing chunk go
  // straight into data_out on the same edge it is accepted.
  logic [WORD_W-1:0]  asm_word;

  assign ready_out = (state_reg != FULL);
  assign accept    = bus.valid_in && ready_out;
  // Holding register can take a new word if empty or being emptied now.
  assign out_free  = !valid_out_reg || bus.ready_in;

  // Assembly slots. No reset needed: every slot is rewritten before a
  // symbol can be copied out, so stale contents never leak.
  generate
    for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_slot
      logic slot_we;
      assign slot_we = wr_en && (wr_idx == CNT_W'(gi));

      always_ff @(posedge clk) begin
        if (slot_we) begin
          asm_reg[gi] <= bus.data_in;
        end
      end

      assign asm_word[gi*CHUNK_W +: CHUNK_W] = slot_we ? bus.data_in : asm_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    frame_err_next = 1'b0;
    wr_en          = 1'b0;
    wr_idx         = '0;
    copy           = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          if (bus.sof_in) begin
            wr_en      = 1'b1;
            count_next = CNT_W'(1);
            state_next = COLLECT;
          end else begin
            // Stray chunk with no frame open: drop it.
            frame_err_next = 1'b1;
          end
        end
      end

      COLLECT: begin
        if (accept) begin
          wr_en = 1'b1;
          if (bus.sof_in) begin
            // New frame starts on top of a partial one: restart at slot 0.
            frame_err_next = 1'b1;
            count_next     = CNT_W'(1);
          end else begin
            wr_idx = count_reg;
            if (count_reg == LAST_IDX) begin
              if (out_free) begin
                copy       = 1'b1;
                count_next = '0;
                state_next = IDLE;
              end else begin
                count_next = FULL_CNT;
                state_next = FULL;
              end
            end else begin
              count_next = count_reg + CNT_W'(1);
            end
          end
        end
      end

      FULL: begin
        if (out_free) begin
          copy       = 1'b1;
          count_next = '0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // Output holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out_reg <= 1'b0;
      data_out_reg  <= '0;
    end else if (copy) begin
      valid_out_reg <= 1'b1;
      data_out_reg  <= asm_word;
    end else if (valid_out_reg && bus.ready_in) begin
      valid_out_reg <= 1'b0;
    end
  end

  assign bus.ready_out   = ready_out;
  assign bus.data_out    = data_out_reg;
  assign bus.valid_out   = valid_out_reg;
  assign bus.frame_err   = frame_err_reg;
  assign bus.chunk_count = count_reg;

endmodule
